preif_pc_gen: RTL and testbench
===============================

Name: preif_pc_gen

Overview:
- Pre-IF stage of the in-order LoongArch pipeline.
- Owns the fetch PC and chooses between sequential, branch, exception-entry and ERTN targets.
- Issues the synchronous instruction-SRAM read.
- Owns the PreIF→IF pipeline register, and drives the IF stage's `pi_to_ibus` PC and `if_valid` qualifier.

Parameters:
- RESET_PC, 32'h1c00_0000, first PC fetched after reset
- PC_W, 32, PC / address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- if_allowin_i  in  1  IF stage can accept a new PC this cycle
- br_stall_i  in  1  branch in ID not yet resolved; hold fetch
- br_taken_i  in  1  single-cycle pulse: taken branch/jump resolved in ID
- br_target_i  in  PC_W  branch target, valid with br_taken_i
- excep_flush_i  in  1  exception commit pulse from WB
- excep_entry_pc_i  in  PC_W  exception entry (CSR.EENTRY)
- ertn_flush_i  in  1  ERTN commit pulse from WB
- ertn_pc_i  in  PC_W  return PC (CSR.ERA)
- inst_sram_en_o  out  1  instruction SRAM read enable
- inst_sram_addr_o  out  PC_W  instruction SRAM read address
- if_valid_o  out  1  IF stage holds a valid PC (IF's if_valid_i)
- pi_to_ibus_o  out  PC_W  PC presented to IF (IF's pi_to_ibus)

Behaviour:
- Registers:
  - preif_valid_q: PreIF is live.
  - next_pc_q: PC to fetch when there is no redirect.
  - if_valid_q: drives if_valid_o.
  - if_pc_q: drives pi_to_ibus_o.
- Reset (rst_n=0 at a clk edge), all synchronous, no output depends combinationally on rst_n:
  - preif_valid_q=0, next_pc_q=RESET_PC, if_valid_q=0, if_pc_q=0.
  - Consequently inst_sram_en_o=0, if_valid_o=0, pi_to_ibus_o=0.
- preif_valid_q becomes 1 on the first edge with rst_n=1 and stays 1.
- Flush = excep_flush_i | ertn_flush_i.
- fetch_pc is a combinational priority mux:
  1. excep_flush_i → excep_entry_pc_i
  2. ertn_flush_i → ertn_pc_i
  3. br_taken_i → br_target_i
  4. otherwise → next_pc_q
- fire = preif_valid_q & (flush | (if_allowin_i & ~br_stall_i)).
  - A flush overrides a stall; downstream is being emptied, so IF is treated as accepting.
- Fetch request:
  - inst_sram_en_o = fire; inst_sram_addr_o = fetch_pc.
  - SRAM data returns the next cycle, aligned with if_pc_q.
  - When fire=0, the SRAM output is held because en=0.
- Updates on each edge (rst_n=1):
  - If fire: if_pc_q<=fetch_pc, if_valid_q<=1, next_pc_q<=fetch_pc+4 (mod 2^PC_W, wraps silently).
  - Else if br_taken_i: if_valid_q<=0 (wrong-path instruction squashed), next_pc_q<=br_target_i.
  - Else if if_allowin_i: if_valid_q<=0 (IF drained, nothing new); if_pc_q and next_pc_q hold.
  - Else: all hold (IF stalled).
- Simultaneous events:
  - excep_flush_i with ertn_flush_i: exception wins.
  - Flush with br_taken_i: the flush target wins and the branch is discarded.
  - br_taken_i with br_stall_i: no fetch, but the target is captured in next_pc_q, so it is never lost.
- Misaligned targets (low bits ≠ 00) are fetched unchanged; IF raises ADEF. This block performs no alignment check.
- Latency:
  - A redirect presented in cycle N produces inst_sram_addr_o=target in cycle N when fire.
  - In that case if_valid_o=1 with pi_to_ibus_o=target in cycle N+1.
- Reset asserted mid-operation clears everything on that edge. Any pending branch target or in-flight fetch is dropped, and fetching restarts at RESET_PC.

Test Plan:
- Reset release, if_allowin_i=1, no stalls:
  - cycle 1: inst_sram_addr_o=1c000000, en=1.
  - Thereafter pi_to_ibus_o=1c000000, 1c000004, 1c000008 on successive cycles, with if_valid_o=1.
- Hold if_allowin_i=0 for 3 cycles at pi_to_ibus_o=1c000008:
  - inst_sram_en_o=0, and pi_to_ibus_o/if_valid_o stay unchanged.
  - After release, the next fetch is 1c00000c.
- br_taken_i pulse with br_target_i=1c000100 while if_allowin_i=1:
  - same cycle addr=1c000100, next cycle pi_to_ibus_o=1c000100, then 1c000104.
  - Repeat with br_stall_i=1: if_valid_o→0, no fetch; when the stall drops, the fetch is 1c000100.
- excep_flush_i with excep_entry_pc_i=1c008000, together with br_taken_i and br_stall_i=1:
  - fetch 1c008000 that cycle; next cycle pi_to_ibus_o=1c008000, if_valid_o=1.
  - Then ertn_flush_i with ertn_pc_i=1c000040 → fetch 1c000040.
- excep_flush_i and ertn_flush_i in the same cycle → fetch excep_entry_pc_i.
  - Then next_pc_q=FFFFFFFC is fetched, and the following fetch is 00000000 (wrap).
- Assert rst_n=0 for one cycle mid-stream, including during a pending branch:
  - next edge: if_valid_o=0, pi_to_ibus_o=0, en=0.
  - After release, the first fetch is 1c000000, and the pending target is discarded.

Source files
------------

// File: rtl/preif_pc_gen.sv
// Pre-IF stage: owns the fetch PC, picks the next fetch target among
// sequential, branch, exception-entry and ERTN addresses, issues the
// synchronous instruction-SRAM read and holds the PreIF->IF register.
module preif_pc_gen #(
  parameter int             PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c00_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_allowin_i,
  input  logic            br_stall_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            excep_flush_i,
  input  logic [PC_W-1:0] excep_entry_pc_i,
  input  logic            ertn_flush_i,
  input  logic [PC_W-1:0] ertn_pc_i,
  output logic            inst_sram_en_o,
  output logic [PC_W-1:0] inst_sram_addr_o,
  output logic            if_valid_o,
  output logic [PC_W-1:0] pi_to_ibus_o
);

  logic            preif_valid_q;
  logic [PC_W-1:0] next_pc_q;
  logic            if_valid_q;
  logic [PC_W-1:0] if_pc_q;

  logic            flush;
  logic            fire;
  logic [PC_W-1:0] fetch_pc;

  assign flush = excep_flush_i | ertn_flush_i;

  // A flush empties everything downstream, so it fetches even through a stall.
  assign fire = preif_valid_q & (flush | (if_allowin_i & ~br_stall_i));

  // Redirect priority: exception entry, then ERTN, then branch, else sequential.
  always_comb begin
    fetch_pc = next_pc_q;
    if (excep_flush_i) begin
      fetch_pc = excep_entry_pc_i;
    end else if (ertn_flush_i) begin
      fetch_pc = ertn_pc_i;
    end else if (br_taken_i) begin
      fetch_pc = br_target_i;
    end
  end

  assign inst_sram_en_o   = fire;
  assign inst_sram_addr_o = fetch_pc;
  assign if_valid_o       = if_valid_q;
  assign pi_to_ibus_o     = if_pc_q;

  // Advance the fetch PC and the PreIF->IF register; a branch seen while not
  // fetching is remembered in next_pc_q so the target is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      preif_valid_q <= 1'b0;
      next_pc_q     <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
    end else begin
      preif_valid_q <= 1'b1;
      if (fire) begin
        if_pc_q    <= fetch_pc;
        if_valid_q <= 1'b1;
        next_pc_q  <= fetch_pc + PC_W'(4);
      end else if (br_taken_i) begin
        if_valid_q <= 1'b0;
        next_pc_q  <= br_target_i;
      end else if (if_allowin_i) begin
        if_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_preif_pc_gen.sv
// Self-checking bench for preif_pc_gen: directed walk through the fetch,
// stall, branch, flush, wrap and reset scenarios, then randomized traffic
// compared every cycle against a behavioural model of the fetch unit.
module tb_preif_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_allowin_i;
  logic        br_stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        excep_flush_i;
  logic [31:0] excep_entry_pc_i;
  logic        ertn_flush_i;
  logic [31:0] ertn_pc_i;
  logic        inst_sram_en_o;
  logic [31:0] inst_sram_addr_o;
  logic        if_valid_o;
  logic [31:0] pi_to_ibus_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: is the fetcher live, where it would fetch next,
  // and what IF currently holds.
  logic        m_known = 1'b0;
  logic        m_live;
  logic [31:0] m_next;
  logic        m_ifv;
  logic [31:0] m_ifpc;

  preif_pc_gen #(.PC_W(32), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_allowin_i     (if_allowin_i),
    .br_stall_i       (br_stall_i),
    .br_taken_i       (br_taken_i),
    .br_target_i      (br_target_i),
    .excep_flush_i    (excep_flush_i),
    .excep_entry_pc_i (excep_entry_pc_i),
    .ertn_flush_i     (ertn_flush_i),
    .ertn_pc_i        (ertn_pc_i),
    .inst_sram_en_o   (inst_sram_en_o),
    .inst_sram_addr_o (inst_sram_addr_o),
    .if_valid_o       (if_valid_o),
    .pi_to_ibus_o     (pi_to_ibus_o)
  );

  always #5 clk = ~clk;

  // Where the fetcher wants to go this cycle, from the current requests.
  function automatic logic [31:0] model_target();
    if (excep_flush_i)   return excep_entry_pc_i;
    else if (ertn_flush_i) return ertn_pc_i;
    else if (br_taken_i) return br_target_i;
    return m_next;
  endfunction

  // Whether a fetch goes out this cycle.
  function automatic logic model_fetch();
    return m_live && (excep_flush_i || ertn_flush_i || (if_allowin_i && !br_stall_i));
  endfunction

  // Model advance at each clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_known <= 1'b1;
      m_live  <= 1'b0;
      m_next  <= RESET_PC;
      m_ifv   <= 1'b0;
      m_ifpc  <= 32'h0;
    end else begin
      m_live <= 1'b1;
      if (model_fetch()) begin
        m_ifpc <= model_target();
        m_ifv  <= 1'b1;
        m_next <= model_target() + 32'd4;
      end else begin
        if (br_taken_i || if_allowin_i) m_ifv <= 1'b0;
        if (br_taken_i) m_next <= br_target_i;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      checks++;
      if (inst_sram_en_o !== model_fetch() || inst_sram_addr_o !== model_target() ||
          if_valid_o !== m_ifv || pi_to_ibus_o !== m_ifpc) begin
        errors++;
        $display("[TB] FAIL model t=%0t: en=%0b addr=%h v=%0b pc=%h, required en=%0b addr=%h v=%0b pc=%h",
                 $time, inst_sram_en_o, inst_sram_addr_o, if_valid_o, pi_to_ibus_o,
                 model_fetch(), model_target(), m_ifv, m_ifpc);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge so outputs can be sampled.
  task automatic applyStimulus(input logic rst, input logic allow, input logic stall,
                               input logic br, input logic [31:0] tgt,
                               input logic ex, input logic [31:0] expc,
                               input logic er, input logic [31:0] erpc);
    @(posedge clk);
    #1;
    rst_n            = rst;
    if_allowin_i     = allow;
    br_stall_i       = stall;
    br_taken_i       = br;
    br_target_i      = tgt;
    excep_flush_i    = ex;
    excep_entry_pc_i = expc;
    ertn_flush_i     = er;
    ertn_pc_i        = erpc;
    @(negedge clk);
  endtask

  // Plain running cycle: out of reset, IF accepting, no events.
  task automatic idle();
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Hand-computed expectation for one cycle.
  task automatic checkOutput(input string name, input logic en, input logic [31:0] addr,
                             input logic v, input logic [31:0] pc);
    checks++;
    if (inst_sram_en_o !== en || inst_sram_addr_o !== addr ||
        if_valid_o !== v || pi_to_ibus_o !== pc) begin
      errors++;
      $display("[TB] FAIL %s: en=%0b addr=%h v=%0b pc=%h, required en=%0b addr=%h v=%0b pc=%h",
               name, inst_sram_en_o, inst_sram_addr_o, if_valid_o, pi_to_ibus_o, en, addr, v, pc);
    end
  endtask

  initial begin
    rst_n = 0; if_allowin_i = 1; br_stall_i = 0; br_taken_i = 0; br_target_i = 0;
    excep_flush_i = 0; excep_entry_pc_i = 0; ertn_flush_i = 0; ertn_pc_i = 0;

    // Reset and release.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset", 0, 32'h1c000000, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_edge_pending", 0, 32'h1c000000, 0, 32'h0);
    idle();
    checkOutput("first_fetch", 1, 32'h1c000000, 0, 32'h0);
    idle();
    checkOutput("seq0", 1, 32'h1c000004, 1, 32'h1c000000);
    idle();
    checkOutput("seq1", 1, 32'h1c000008, 1, 32'h1c000004);

    // IF stall for three cycles at 1c000008.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall0", 0, 32'h1c00000c, 1, 32'h1c000008);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall1", 0, 32'h1c00000c, 1, 32'h1c000008);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall2", 0, 32'h1c00000c, 1, 32'h1c000008);
    idle();
    checkOutput("stall_release", 1, 32'h1c00000c, 1, 32'h1c000008);

    // Taken branch with IF accepting.
    applyStimulus(1, 1, 0, 1, 32'h1c000100, 0, 0, 0, 0);
    checkOutput("br_fetch", 1, 32'h1c000100, 1, 32'h1c00000c);
    idle();
    checkOutput("br_if", 1, 32'h1c000104, 1, 32'h1c000100);
    idle();
    checkOutput("br_seq", 1, 32'h1c000108, 1, 32'h1c000104);

    // Taken branch during a branch stall: captured, fetched when stall drops.
    applyStimulus(1, 1, 1, 1, 32'h1c000100, 0, 0, 0, 0);
    checkOutput("brstall_pulse", 0, 32'h1c000100, 1, 32'h1c000108);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("brstall_squash", 0, 32'h1c000100, 0, 32'h1c000108);
    idle();
    checkOutput("brstall_release", 1, 32'h1c000100, 0, 32'h1c000108);
    idle();
    checkOutput("brstall_if", 1, 32'h1c000104, 1, 32'h1c000100);

    // Exception beats both a branch and a stall; then ERTN.
    applyStimulus(1, 1, 1, 1, 32'h1c000300, 1, 32'h1c008000, 0, 0);
    checkOutput("excep_fetch", 1, 32'h1c008000, 1, 32'h1c000104);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 32'h1c000040);
    checkOutput("ertn_fetch", 1, 32'h1c000040, 1, 32'h1c008000);

    // Exception beats ERTN; then sequential fetch wraps past the top.
    applyStimulus(1, 1, 0, 0, 0, 1, 32'hfffffff8, 1, 32'h1c000040);
    checkOutput("excep_over_ertn", 1, 32'hfffffff8, 1, 32'h1c000040);
    idle();
    checkOutput("wrap_top", 1, 32'hfffffffc, 1, 32'hfffffff8);
    idle();
    checkOutput("wrap_zero", 1, 32'h00000000, 1, 32'hfffffffc);
    idle();
    checkOutput("wrap_after", 1, 32'h00000004, 1, 32'h00000000);

    // Reset mid-stream while a branch target is pending.
    applyStimulus(1, 1, 1, 1, 32'h1c000500, 0, 0, 0, 0);
    checkOutput("pend_branch", 0, 32'h1c000500, 1, 32'h00000004);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("pend_captured", 0, 32'h1c000500, 0, 32'h00000004);
    idle();
    checkOutput("mid_reset", 0, 32'h1c000000, 0, 32'h0);
    idle();
    checkOutput("restart_fetch", 1, 32'h1c000000, 0, 32'h0);
    idle();
    checkOutput("restart_if", 1, 32'h1c000004, 1, 32'h1c000000);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 59) != 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0, $urandom(),
                    $urandom_range(0, 11) == 0, $urandom(),
                    $urandom_range(0, 11) == 0, $urandom());
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
